tinyml_hw_accel_nearest_neighbor_upscale: RTL and testbench
===========================================================

Name: tinyml_hw_accel_nearest_neighbor_upscale

Overview:
Streaming nearest-neighbour upscaler for single-channel pixel streams at 1 pixel per clock. It enlarges a frame of IN_FRAME_WIDTH x IN_FRAME_HEIGHT to OUT_FRAME_WIDTH x OUT_FRAME_HEIGHT.
- Sits downstream of the downscaler in the accelerator pipeline, e.g. to restore a model-resolution mask to display resolution.
- Output rate exceeds input rate, so both sides use valid/ready.
- Holds one input row in an internal line buffer.

Parameters:
- PIXEL_DATA_WIDTH, 8, bits per pixel.
- IN_FRAME_WIDTH, 3, input pixels per row; legal range 1..2047.
- IN_FRAME_HEIGHT, 3, input rows per frame.
- OUT_FRAME_WIDTH, 8, output pixels per row; must be >= IN_FRAME_WIDTH, max 2047.
- OUT_FRAME_HEIGHT, 8, output rows per frame; must be >= IN_FRAME_HEIGHT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_pixel_data  in  PIXEL_DATA_WIDTH  input pixel, raster order.
- in_pixel_data_valid  in  1  input pixel valid.
- in_pixel_data_ready  out  1  block accepts the input pixel this cycle.
- out_pixel_data  out  PIXEL_DATA_WIDTH  output pixel, raster order.
- out_pixel_data_valid  out  1  output pixel valid.
- out_pixel_data_ready  in  1  downstream accepts the output pixel.
- out_frame_done  out  1  one-cycle pulse on acceptance of the last output pixel of a frame.

Behaviour:
- Ratios:
  - X_RATIO = ((IN_FRAME_WIDTH<<16)/OUT_FRAME_WIDTH)+1.
  - Y_RATIO is defined the same way with the heights.
  - src_x(ox) = (ox*X_RATIO)>>16 and src_y(oy) = (oy*Y_RATIO)>>16, bit-exact.
  - Implement with 27-bit accumulators: x_acc adds X_RATIO per issued pixel, y_acc adds Y_RATIO per finished output row. No runtime multiplier.
- Handshake:
  - A transfer occurs when valid&ready are both high.
  - out_pixel_data and out_pixel_data_valid hold steady while valid=1 and ready=0.
- FSM states: FILL, EMIT.
- Reset values: state=FILL; ix=iy=ox=oy=0; x_acc=y_acc=0; in_pixel_data_ready=0 during rst, 1 in the first cycle after reset; out_pixel_data=0; out_pixel_data_valid=0; out_frame_done=0.
- FILL state:
  - in_pixel_data_ready=1.
  - Each transfer writes line_buf[ix] and increments ix.
  - On the transfer with ix==IN_FRAME_WIDTH-1: ix<=0, move to EMIT. in_pixel_data_ready drops the next cycle.
- EMIT state:
  - in_pixel_data_ready=0.
  - Issue condition: !out_pixel_data_valid | out_pixel_data_ready.
  - On issue: synchronous read of line_buf[x_acc>>16]; the data lands in out_pixel_data next cycle with out_pixel_data_valid=1.
  - The RAM output register is out_pixel_data, clock-enabled by the issue condition.
  - Latency from first issue to first out valid: 1 cycle. Throughput: 1 pixel/clk when out_pixel_data_ready=1.
  - End of row (ox==OUT_FRAME_WIDTH-1 issued): ox<=0, x_acc<=0, oy++, y_acc+=Y_RATIO.
  - If the new src_y != iy: iy++ and go to FILL.
  - If oy wraps at OUT_FRAME_HEIGHT: oy=iy=y_acc=0 and go to FILL.
  - Otherwise repeat the row from the buffer.
  - src_y advances by at most 1 per output row because OUT>=IN.
- FILL may begin while the last EMIT pixel is still held in the output register. The buffer write does not disturb out_pixel_data.
- out_frame_done asserts on the cycle the final pixel (ox=OUT_W-1, oy=OUT_H-1) transfers.
- Assertions:
  - in_pixel_data_valid while in EMIT is ignored (not accepted).
  - Parameters with OUT<IN are illegal; elaboration $error.
- Reset mid-frame: all state returns to reset values the next cycle; buffer contents are don't-care.
- Counter widths: 11 bits.

Decomposition:
- Shared package tinyml_hw_accel_pkg:
  - ratio function nn_ratio(in,out);
  - FSM state typedef;
  - counter width constant CNT_W=11.
- Sub-module tinyml_hw_accel_line_buffer: simple dual-port RAM with depth IN_FRAME_WIDTH, sync write, sync read with read-enable. Reusable by later blocks.

Test Plan:
- IN 2x2, OUT 4x4, inputs 1,2,3,4, out_pixel_data_ready=1 -> output rows [1,1,2,2],[1,1,2,2],[3,3,4,4],[3,3,4,4]; out_frame_done pulses once with the 16th pixel.
- IN 3x3, OUT 8x8, row0 = 10,20,30 -> each of output rows 0..2 = 10,10,10,20,20,20,30,30; input row1 is not accepted until output row 2 completes.
- IN=OUT=4x4 identity -> output equals input; exactly 16 out transfers per frame.
- Random out_pixel_data_ready (50%) on the 3x3->8x8 case -> data identical to the no-stall run; out_pixel_data stable during every stall cycle.
- rst asserted mid-EMIT of row 1 -> next cycle out_pixel_data_valid=0 and in_pixel_data_ready=1; a fresh frame then produces correct output from row 0.
- Two back-to-back frames with in_pixel_data_valid held high -> in_pixel_data_ready=0 throughout EMIT; second frame output correct; out_frame_done pulses twice.

Source files
------------

// File: rtl/tinyml_hw_accel_pkg.sv
// ---------------------------------------------------------------------------
// tinyml_hw_accel_pkg
// Shared definitions for the TinyML accelerator pixel-stream blocks.
//   CNT_W      : width of pixel/row counters (frames up to 2047 wide/high)
//   ACC_W      : width of the 16.16-style fixed-point scale accumulators
//   nn_state_e : FILL/EMIT state of the nearest-neighbour upscaler
//   nn_ratio() : fixed-point source step per output pixel/row
// ---------------------------------------------------------------------------
package tinyml_hw_accel_pkg;

    localparam int CNT_W = 11;
    localparam int ACC_W = 27;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } nn_state_e;

    // The +1 biases the step upward so that the last output coordinate still
    // truncates onto the last source coordinate instead of one short of it.
    function automatic logic [ACC_W-1:0] nn_ratio(input int unsigned in_dim,
                                                  input int unsigned out_dim);
        nn_ratio = ACC_W'(((in_dim << 16) / out_dim) + 1);
    endfunction

endpackage

// File: rtl/tinyml_hw_accel_line_buffer.sv
// ---------------------------------------------------------------------------
// tinyml_hw_accel_line_buffer
// Simple dual-port RAM holding one row of pixels.
//   clk       : clock
//   rst       : synchronous active-high reset, clears the read register only
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read enable; also the clock enable of the read register
//   i_rd_addr : read address
//   o_rd_data : registered read data, valid the cycle after i_rd_en
// ---------------------------------------------------------------------------
module tinyml_hw_accel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register holds its value when i_rd_en is low, so a consumer
    // can use it directly as a stalled output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/tinyml_hw_accel_nearest_neighbor_upscale.sv
// ---------------------------------------------------------------------------
// tinyml_hw_accel_nearest_neighbor_upscale
// Streaming nearest-neighbour upscaler, single channel, 1 pixel/clk.
// Buffers one input row (FILL), then replays it as one or more output rows
// (EMIT), stepping source coordinates with fixed-point accumulators.
//   clk                  : clock
//   rst                  : synchronous active-high reset
//   in_pixel_data        : input pixel, raster order
//   in_pixel_data_valid  : input pixel valid
//   in_pixel_data_ready  : input pixel accepted this cycle (FILL only)
//   out_pixel_data       : output pixel, raster order
//   out_pixel_data_valid : output pixel valid
//   out_pixel_data_ready : downstream accepts the output pixel
//   out_frame_done       : pulse when the last output pixel of a frame transfers
// ---------------------------------------------------------------------------
module tinyml_hw_accel_nearest_neighbor_upscale
    import tinyml_hw_accel_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int IN_FRAME_WIDTH   = 3,
    parameter int IN_FRAME_HEIGHT  = 3,
    parameter int OUT_FRAME_WIDTH  = 8,
    parameter int OUT_FRAME_HEIGHT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel_data,
    input  logic                        in_pixel_data_valid,
    output logic                        in_pixel_data_ready,
    output logic [PIXEL_DATA_WIDTH-1:0] out_pixel_data,
    output logic                        out_pixel_data_valid,
    input  logic                        out_pixel_data_ready,
    output logic                        out_frame_done
);

    if (OUT_FRAME_WIDTH < IN_FRAME_WIDTH || OUT_FRAME_HEIGHT < IN_FRAME_HEIGHT) begin : g_bad_ratio
        $error("upscaler: output dimensions must be >= input dimensions");
    end
    if (IN_FRAME_WIDTH < 1 || OUT_FRAME_WIDTH > 2047) begin : g_bad_width
        $error("upscaler: frame widths must lie in 1..2047");
    end

    localparam logic [ACC_W-1:0] X_RATIO    = nn_ratio(IN_FRAME_WIDTH, OUT_FRAME_WIDTH);
    localparam logic [ACC_W-1:0] Y_RATIO    = nn_ratio(IN_FRAME_HEIGHT, OUT_FRAME_HEIGHT);
    localparam int               LB_AW      = (IN_FRAME_WIDTH > 1) ? $clog2(IN_FRAME_WIDTH) : 1;
    localparam logic [CNT_W-1:0] IN_W_LAST  = CNT_W'(IN_FRAME_WIDTH - 1);
    localparam logic [CNT_W-1:0] OUT_W_LAST = CNT_W'(OUT_FRAME_WIDTH - 1);
    localparam logic [CNT_W-1:0] OUT_H_LAST = CNT_W'(OUT_FRAME_HEIGHT - 1);

    nn_state_e        r_state;
    nn_state_e        w_next_state;
    logic [CNT_W-1:0] r_ix;
    logic [CNT_W-1:0] r_iy;
    logic [CNT_W-1:0] r_ox;
    logic [CNT_W-1:0] r_oy;
    logic [ACC_W-1:0] r_x_acc;
    logic [ACC_W-1:0] r_y_acc;
    logic             r_out_valid;
    logic             r_last;

    logic             w_in_fire;
    logic             w_issue;
    logic             w_row_end;
    logic             w_frame_end;
    logic [ACC_W-1:0] w_y_acc_next;
    logic [CNT_W-1:0] w_src_y_next;
    logic             w_new_src_row;
    logic [CNT_W-1:0] w_src_x;
    logic [CNT_W-1:0] w_rd_x;

    // Next-state and handshake decode
    always_comb begin
        w_next_state        = r_state;
        in_pixel_data_ready = (r_state == ST_FILL) && !rst;
        w_in_fire           = in_pixel_data_valid && in_pixel_data_ready;
        // The output register may only be reloaded when it is empty or being
        // drained this cycle; this is what keeps data stable under stall.
        w_issue             = (r_state == ST_EMIT) && (!r_out_valid || out_pixel_data_ready);
        w_row_end           = w_issue && (r_ox == OUT_W_LAST);
        w_frame_end         = w_row_end && (r_oy == OUT_H_LAST);
        w_y_acc_next        = r_y_acc + Y_RATIO;
        w_src_y_next        = w_y_acc_next[ACC_W-1:16];
        // Source row advances by at most one per output row since OUT >= IN.
        w_new_src_row       = (w_src_y_next != r_iy);

        case (r_state)
            ST_FILL: begin
                if (w_in_fire && (r_ix == IN_W_LAST)) begin
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_frame_end || (w_row_end && w_new_src_row)) begin
                    w_next_state = ST_FILL;
                end
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    // Extreme ratios can push the truncated x coordinate one past the row;
    // clamp so the RAM is never addressed out of range.
    always_comb begin
        w_src_x = r_x_acc[ACC_W-1:16];
        w_rd_x  = (w_src_x > IN_W_LAST) ? IN_W_LAST : w_src_x;
    end

    // State, counters and output-valid register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_ix        <= '0;
            r_iy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_x_acc     <= '0;
            r_y_acc     <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_in_fire) begin
                r_ix <= (r_ix == IN_W_LAST) ? '0 : r_ix + 1'b1;
            end

            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_last      <= w_frame_end;
                if (w_row_end) begin
                    r_ox    <= '0;
                    r_x_acc <= '0;
                    if (w_frame_end) begin
                        r_oy    <= '0;
                        r_iy    <= '0;
                        r_y_acc <= '0;
                    end else begin
                        r_oy    <= r_oy + 1'b1;
                        r_y_acc <= w_y_acc_next;
                        if (w_new_src_row) begin
                            r_iy <= r_iy + 1'b1;
                        end
                    end
                end else begin
                    r_ox    <= r_ox + 1'b1;
                    r_x_acc <= r_x_acc + X_RATIO;
                end
            end else if (out_pixel_data_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Row storage; its read register is the output pixel register
    tinyml_hw_accel_line_buffer #(
        .DATA_W (PIXEL_DATA_WIDTH),
        .DEPTH  (IN_FRAME_WIDTH),
        .ADDR_W (LB_AW)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_in_fire),
        .i_wr_addr (LB_AW'(r_ix)),
        .i_wr_data (in_pixel_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (LB_AW'(w_rd_x)),
        .o_rd_data (out_pixel_data)
    );

    assign out_pixel_data_valid = r_out_valid;
    assign out_frame_done       = r_out_valid && out_pixel_data_ready && r_last && !rst;

    a_no_accept_in_emit: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_EMIT) |-> !w_in_fire);

endmodule

// File: tb/tb_tinyml_hw_accel_nearest_neighbor_upscale.sv
`timescale 1ns/1ps
module tb_tinyml_hw_accel_nearest_neighbor_upscale;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] out_data  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       done      [3];

    always #5 clk = ~clk;

    // Instance 0: 2x2 -> 4x4, instance 1: 3x3 -> 8x8, instance 2: 4x4 identity
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P_IW = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
        localparam int P_OW = (g == 0) ? 4 : ((g == 1) ? 8 : 4);
        tinyml_hw_accel_nearest_neighbor_upscale #(
            .PIXEL_DATA_WIDTH (8),
            .IN_FRAME_WIDTH   (P_IW),
            .IN_FRAME_HEIGHT  (P_IW),
            .OUT_FRAME_WIDTH  (P_OW),
            .OUT_FRAME_HEIGHT (P_OW)
        ) u_dut (
            .clk                  (clk),
            .rst                  (rst),
            .in_pixel_data        (in_data[g]),
            .in_pixel_data_valid  (in_valid[g]),
            .in_pixel_data_ready  (in_ready[g]),
            .out_pixel_data       (out_data[g]),
            .out_pixel_data_valid (out_valid[g]),
            .out_pixel_data_ready (out_ready[g]),
            .out_frame_done       (done[g])
        );
    end

    typedef struct {
        int          k;
        int          oy;
        logic [63:0] row;   // first output pixel in the top byte
    } row_vec_t;

    row_vec_t   vecs [16];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] in_q  [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         done_q[$];
    logic [7:0] dir_got [3][64];
    int         n_done;
    int         stall_err;
    int         out_at_row1;

    function automatic int in_dim(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int out_dim(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 4);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_q();
        in_q.delete(); exp_q.delete(); got_q.delete(); done_q.delete();
    endtask

    // Reference model: pick the source pixel for every output coordinate
    // directly from the scale formula (multiply, not accumulate).
    task automatic gen_frame(input int k, input int random_pix);
        int         iw;
        int         ow;
        longint     ratio;
        logic [7:0] pix [16];
        iw    = in_dim(k);
        ow    = out_dim(k);
        ratio = ((longint'(iw) << 16) / ow) + 1;
        for (int i = 0; i < iw * iw; i++) begin
            if (random_pix != 0)  pix[i] = 8'($urandom_range(255));
            else if (k == 1)      pix[i] = 8'(10 * (i + 1));
            else                  pix[i] = 8'(i + 1);
            in_q.push_back(pix[i]);
        end
        for (int oy = 0; oy < ow; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                int sy;
                int sx;
                sy = int'((longint'(oy) * ratio) >> 16);
                sx = int'((longint'(ox) * ratio) >> 16);
                exp_q.push_back(pix[sy * iw + sx]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 8'h00; out_ready[k] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives in_q into instance k and collects n_out output pixels. Once in_q
    // is empty, valid stays high with junk so any illegal accept corrupts data.
    task automatic run(input int k, input int stall_pct, input int gap_pct,
                       input int n_out, input int rst_at);
        int         cyc;
        int         n_acc;
        bit         prev_stall;
        logic [7:0] prev_data;
        cyc = 0; n_acc = 0; prev_stall = 0; prev_data = 0;
        n_done = 0; stall_err = 0; out_at_row1 = -1;
        while (int'(got_q.size()) < n_out && cyc < 4000) begin
            @(negedge clk);
            if (in_q.size() == 0) begin
                in_valid[k] = 1'b1; in_data[k] = 8'hEE;
            end else if (int'($urandom_range(99)) < gap_pct) begin
                in_valid[k] = 1'b0; in_data[k] = 8'hEE;
            end else begin
                in_valid[k] = 1'b1; in_data[k] = in_q[0];
            end
            out_ready[k] = (int'($urandom_range(99)) >= stall_pct);
            #1;
            if (prev_stall && (!out_valid[k] || out_data[k] !== prev_data)) stall_err++;
            if (done[k]) n_done++;
            if (out_valid[k] && out_ready[k]) begin
                got_q.push_back(out_data[k]);
                done_q.push_back(done[k]);
            end
            if (in_valid[k] && in_ready[k] && in_q.size() > 0) begin
                void'(in_q.pop_front());
                n_acc++;
                if (n_acc == in_dim(k) + 1) out_at_row1 = got_q.size();
            end
            prev_stall = out_valid[k] && !out_ready[k];
            prev_data  = out_data[k];
            cyc++;
            if (rst_at >= 0 && int'(got_q.size()) >= rst_at) break;
        end
        check($sformatf("run_budget_k%0d", k), cyc < 4000, 1);
    endtask

    task automatic check_stream(input string name, input int fs, input int nframes);
        int mism;
        int pos_err;
        mism = 0; pos_err = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
        for (int i = 0; i < done_q.size(); i++)
            if (done_q[i] != ((i % fs) == fs - 1)) pos_err++;
        check({name, "_len"}, got_q.size(), exp_q.size());
        check({name, "_data_errs"}, mism, 0);
        check({name, "_done_pos_errs"}, pos_err, 0);
        check({name, "_done_cnt"}, n_done, nframes);
    endtask

    task automatic check_no_extra(input int k);
        int extra;
        extra = 0;
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid[k]) extra++;
        end
        check($sformatf("extra_out_k%0d", k), extra, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] keep_in  [$];
        logic [7:0] keep_exp [$];

        vecs[0]  = '{0, 0, 64'h01_01_02_02_00_00_00_00};
        vecs[1]  = '{0, 1, 64'h01_01_02_02_00_00_00_00};
        vecs[2]  = '{0, 2, 64'h03_03_04_04_00_00_00_00};
        vecs[3]  = '{0, 3, 64'h03_03_04_04_00_00_00_00};
        vecs[4]  = '{1, 0, 64'h0A_0A_0A_14_14_14_1E_1E};
        vecs[5]  = '{1, 1, 64'h0A_0A_0A_14_14_14_1E_1E};
        vecs[6]  = '{1, 2, 64'h0A_0A_0A_14_14_14_1E_1E};
        vecs[7]  = '{1, 3, 64'h28_28_28_32_32_32_3C_3C};
        vecs[8]  = '{1, 4, 64'h28_28_28_32_32_32_3C_3C};
        vecs[9]  = '{1, 5, 64'h28_28_28_32_32_32_3C_3C};
        vecs[10] = '{1, 6, 64'h46_46_46_50_50_50_5A_5A};
        vecs[11] = '{1, 7, 64'h46_46_46_50_50_50_5A_5A};
        vecs[12] = '{2, 0, 64'h01_02_03_04_00_00_00_00};
        vecs[13] = '{2, 1, 64'h05_06_07_08_00_00_00_00};
        vecs[14] = '{2, 2, 64'h09_0A_0B_0C_00_00_00_00};
        vecs[15] = '{2, 3, 64'h0D_0E_0F_10_00_00_00_00};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 8'h00; out_ready[k] = 1'b1;
        end

        // Reset state: ready high in the first cycle after reset, outputs idle
        do_reset();
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state_k%0d", k),
                  {in_ready[k], out_valid[k], done[k], out_data[k]},
                  {1'b1, 1'b0, 1'b0, 8'h00});

        // Directed frames, no stall
        for (int k = 0; k < 3; k++) begin
            int fs;
            fs = out_dim(k) * out_dim(k);
            do_reset();
            clear_q();
            gen_frame(k, 0);
            run(k, 0, 0, fs, -1);
            for (int i = 0; i < 64; i++) dir_got[k][i] = (i < got_q.size()) ? got_q[i] : 8'hXX;
            check_stream($sformatf("directed_k%0d", k), fs, 1);
            if (k == 1) check("row1_accept_after_out_row2", out_at_row1, 24);
            check_no_extra(k);
        end

        // Table of hand-derived output rows against the directed captures
        for (int j = 0; j < 16; j++) begin
            int mism;
            int ow;
            mism = 0;
            ow   = out_dim(vecs[j].k);
            for (int i = 0; i < ow; i++)
                if (dir_got[vecs[j].k][vecs[j].oy * ow + i] !== vecs[j].row[8*(7-i) +: 8]) mism++;
            check($sformatf("table_k%0d_row%0d_errs", vecs[j].k, vecs[j].oy), mism, 0);
        end

        // Random pixels on 3x3->8x8: no stall, then same data with 50% stall
        do_reset();
        clear_q();
        gen_frame(1, 1);
        keep_in  = in_q;
        keep_exp = exp_q;
        run(1, 0, 0, 64, -1);
        check_stream("rand_k1_nostall", 64, 1);
        do_reset();
        clear_q();
        in_q  = keep_in;
        exp_q = keep_exp;
        run(1, 50, 30, 64, -1);
        check_stream("rand_k1_stall", 64, 1);
        check("rand_k1_stall_stability_errs", stall_err, 0);

        // Random pixels and stalls on the other geometries
        for (int k = 0; k < 3; k += 2) begin
            do_reset();
            clear_q();
            gen_frame(k, 1);
            run(k, 30, 30, out_dim(k) * out_dim(k), -1);
            check_stream($sformatf("rand_k%0d_stall", k), out_dim(k) * out_dim(k), 1);
            check($sformatf("rand_k%0d_stability_errs", k), stall_err, 0);
        end

        // Reset in the middle of output row 1, then a fresh frame
        do_reset();
        clear_q();
        gen_frame(1, 0);
        run(1, 0, 0, 64, 11);
        rst = 1'b1;
        in_valid[1] = 1'b0;
        #1;
        check("midrst_ready_during_rst", in_ready[1], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid[1], 0);
        check("midrst_in_ready", in_ready[1], 1);
        check("midrst_out_data", out_data[1], 0);
        clear_q();
        gen_frame(1, 0);
        run(1, 0, 0, 64, -1);
        check_stream("midrst_fresh", 64, 1);

        // Two back-to-back frames with input valid held high
        do_reset();
        clear_q();
        gen_frame(1, 1);
        gen_frame(1, 1);
        run(1, 0, 0, 128, -1);
        check_stream("b2b_k1", 64, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
